// File: rtl/aqed_fc_monitor_if.sv
// Stream-side bundle observed by the A-QED functional-consistency monitor.
// The harness drives the master side; the monitor listens on the slave side.
interface aqed_fc_monitor_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              exec_orig;
  logic              exec_dup;

  modport master (
    output in_valid, in_data, out_valid, out_data, exec_orig, exec_dup
  );

  modport slave (
    input in_valid, in_data, out_valid, out_data, exec_orig, exec_dup
  );
endinterface

// File: rtl/aqed_fc_monitor.sv
// A-QED functional-consistency monitor: captures an original/duplicate input pair,
// records their outputs and flags a mismatch; also tracks per-frame traffic.
// Optional macro AQED_SAME_POS_EN: duplicate must sit at the original's frame position.
module aqed_fc_monitor #(
  parameter int DATA_W = 16,
  parameter int SEQ_W  = 16,
  parameter int FRM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  aqed_fc_monitor_if.slave  bus,
  input  logic [FRM_W-1:0]  depth,
  output logic [FRM_W-1:0]  in_fcnt,
  output logic [FRM_W-1:0]  out_fcnt,
  output logic              in_frame_full,
  output logic              out_frame_full,
  output logic              orig_captured,
  output logic              dup_captured,
  output logic              qed_done,
  output logic              qed_check
);
  localparam logic [SEQ_W-1:0] SEQ_MAX = {SEQ_W{1'b1}};
  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  logic [SEQ_W-1:0]  in_seq_q, in_seq_d, out_seq_q, out_seq_d;
  logic [SEQ_W-1:0]  orig_idx_q, orig_idx_d, dup_idx_q, dup_idx_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [DATA_W-1:0] orig_out_q, orig_out_d, dup_out_q, dup_out_d;
  logic              orig_captured_q, orig_captured_d, dup_captured_q, dup_captured_d;
  logic              orig_out_v_q, orig_out_v_d, dup_out_v_q, dup_out_v_d;
  logic              qed_done_q, qed_done_d, qed_check_q, qed_check_d;
  logic [FRM_W-1:0]  in_fcnt_q, in_fcnt_d, out_fcnt_q, out_fcnt_d;
`ifdef AQED_SAME_POS_EN
  logic [FRM_W-1:0]  orig_pos_q, orig_pos_d;
`endif

  logic              in_fire_s, out_fire_s, in_seq_sat_s, pos_ok_s;
  logic              orig_cap_s, dup_cap_s, orig_rec_s, dup_rec_s, done_set_s;
  logic              in_step_s, out_step_s;
  logic [FRM_W-1:0]  in_next_s, out_next_s;

  // Capture, recording, completion and frame-count next-state logic
  always_comb begin
    in_fire_s    = clk_en & bus.in_valid;
    out_fire_s   = clk_en & bus.out_valid;
    in_seq_sat_s = (in_seq_q == SEQ_MAX);
`ifdef AQED_SAME_POS_EN
    pos_ok_s     = (in_fcnt_q == orig_pos_q);
`else
    pos_ok_s     = 1'b1;
`endif

    // Captures compare against registered flags, so exec_dup in the original's cycle is ignored
    orig_cap_s = in_fire_s & bus.exec_orig & ~orig_captured_q & ~in_seq_sat_s;
    dup_cap_s  = in_fire_s & bus.exec_dup & orig_captured_q & ~dup_captured_q &
                 ~in_seq_sat_s & (bus.in_data == orig_data_q) & pos_ok_s;
    orig_rec_s = out_fire_s & orig_captured_q & ~orig_out_v_q & (out_seq_q == orig_idx_q);
    dup_rec_s  = out_fire_s & dup_captured_q & ~dup_out_v_q & (out_seq_q == dup_idx_q);
    done_set_s = clk_en & orig_out_v_q & dup_out_v_q & ~qed_done_q;

    in_seq_d        = in_seq_q;
    out_seq_d       = out_seq_q;
    orig_idx_d      = orig_idx_q;
    dup_idx_d       = dup_idx_q;
    orig_data_d     = orig_data_q;
    orig_out_d      = orig_out_q;
    dup_out_d       = dup_out_q;
    orig_captured_d = orig_captured_q;
    dup_captured_d  = dup_captured_q;
    orig_out_v_d    = orig_out_v_q;
    dup_out_v_d     = dup_out_v_q;
    qed_done_d      = qed_done_q;
    qed_check_d     = qed_check_q;
`ifdef AQED_SAME_POS_EN
    orig_pos_d      = orig_pos_q;
`endif

    if (in_fire_s && !in_seq_sat_s) in_seq_d = in_seq_q + SEQ_ONE;
    else                            in_seq_d = in_seq_q;
    if (out_fire_s && (out_seq_q != SEQ_MAX)) out_seq_d = out_seq_q + SEQ_ONE;
    else                                      out_seq_d = out_seq_q;

    if (orig_cap_s) begin
      orig_data_d     = bus.in_data;
      orig_idx_d      = in_seq_q;
      orig_captured_d = 1'b1;
`ifdef AQED_SAME_POS_EN
      orig_pos_d      = in_fcnt_q;
`endif
    end else begin
      orig_captured_d = orig_captured_q;
    end

    if (dup_cap_s) begin
      dup_idx_d      = in_seq_q;
      dup_captured_d = 1'b1;
    end else begin
      dup_captured_d = dup_captured_q;
    end

    if (orig_rec_s) begin
      orig_out_d   = bus.out_data;
      orig_out_v_d = 1'b1;
    end else begin
      orig_out_v_d = orig_out_v_q;
    end

    if (dup_rec_s) begin
      dup_out_d   = bus.out_data;
      dup_out_v_d = 1'b1;
    end else begin
      dup_out_v_d = dup_out_v_q;
    end

    if (done_set_s) begin
      qed_done_d  = 1'b1;
      qed_check_d = (orig_out_q == dup_out_q);
    end else begin
      qed_done_d  = qed_done_q;
    end

    // Frame counters stop at depth and jointly wrap once both sides complete the frame
    in_step_s  = in_fire_s & (in_fcnt_q < depth);
    out_step_s = out_fire_s & (out_fcnt_q < depth);
    in_next_s  = in_fcnt_q + {{(FRM_W-1){1'b0}}, in_step_s};
    out_next_s = out_fcnt_q + {{(FRM_W-1){1'b0}}, out_step_s};
    if (depth == {FRM_W{1'b0}}) begin
      in_fcnt_d  = {FRM_W{1'b0}};
      out_fcnt_d = {FRM_W{1'b0}};
    end else if (!clk_en) begin
      in_fcnt_d  = in_fcnt_q;
      out_fcnt_d = out_fcnt_q;
    end else if ((in_next_s == depth) && (out_next_s == depth)) begin
      in_fcnt_d  = {FRM_W{1'b0}};
      out_fcnt_d = {FRM_W{1'b0}};
    end else begin
      in_fcnt_d  = in_next_s;
      out_fcnt_d = out_next_s;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      in_seq_q        <= {SEQ_W{1'b0}};
      out_seq_q       <= {SEQ_W{1'b0}};
      orig_idx_q      <= {SEQ_W{1'b0}};
      dup_idx_q       <= {SEQ_W{1'b0}};
      orig_data_q     <= {DATA_W{1'b0}};
      orig_out_q      <= {DATA_W{1'b0}};
      dup_out_q       <= {DATA_W{1'b0}};
      orig_captured_q <= 1'b0;
      dup_captured_q  <= 1'b0;
      orig_out_v_q    <= 1'b0;
      dup_out_v_q     <= 1'b0;
      qed_done_q      <= 1'b0;
      qed_check_q     <= 1'b1;
      in_fcnt_q       <= {FRM_W{1'b0}};
      out_fcnt_q      <= {FRM_W{1'b0}};
`ifdef AQED_SAME_POS_EN
      orig_pos_q      <= {FRM_W{1'b0}};
`endif
    end else begin
      in_seq_q        <= in_seq_d;
      out_seq_q       <= out_seq_d;
      orig_idx_q      <= orig_idx_d;
      dup_idx_q       <= dup_idx_d;
      orig_data_q     <= orig_data_d;
      orig_out_q      <= orig_out_d;
      dup_out_q       <= dup_out_d;
      orig_captured_q <= orig_captured_d;
      dup_captured_q  <= dup_captured_d;
      orig_out_v_q    <= orig_out_v_d;
      dup_out_v_q     <= dup_out_v_d;
      qed_done_q      <= qed_done_d;
      qed_check_q     <= qed_check_d;
      in_fcnt_q       <= in_fcnt_d;
      out_fcnt_q      <= out_fcnt_d;
`ifdef AQED_SAME_POS_EN
      orig_pos_q      <= orig_pos_d;
`endif
    end
  end

  assign in_fcnt        = in_fcnt_q;
  assign out_fcnt       = out_fcnt_q;
  assign in_frame_full  = (depth != {FRM_W{1'b0}}) && (in_fcnt_q == depth);
  assign out_frame_full = (depth != {FRM_W{1'b0}}) && (out_fcnt_q == depth);
  assign orig_captured  = orig_captured_q;
  assign dup_captured   = dup_captured_q;
  assign qed_done       = qed_done_q;
  assign qed_check      = qed_check_q;
endmodule
